// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, req/ack fetch to instruction memory, IF/ID register.
// Optional IF_PERF_CNT_EN build macro adds saturating redirect and bubble counters.
module if_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] INST_NOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        Br_taken,
  input  logic [31:0] Br_Addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_Inst,
  output logic        IF_valid,
  output logic [15:0] redir_cnt,
  output logic [15:0] bubble_cnt
);

  typedef enum logic [1:0] {StFetch, StHold, StFlush} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StFetch;
      pc_q       <= PC_RESET;
      skid_q     <= '0;
      if_pc_q    <= '0;
      if_inst_q  <= INST_NOP;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      skid_q     <= skid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    if (Br_taken) begin
      // Redirect beats freeze and ack; any in-flight fetch is drained by a FLUSH cycle.
      pc_d       = Br_Addr;
      if_inst_d  = INST_NOP;
      if_valid_d = 1'b0;
      skid_d     = '0;
      state_d    = (state_q == StHold) ? StFetch : StFlush;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_ack) begin
            if (freeze) begin
              skid_d  = imem_rdata;
              state_d = StHold;
            end else begin
              if_pc_d    = pc_plus4;
              if_inst_d  = imem_rdata;
              if_valid_d = 1'b1;
              pc_d       = pc_plus4;
            end
          end else if (!freeze) begin
            if_inst_d  = INST_NOP;
            if_valid_d = 1'b0;
          end
        end
        StHold: begin
          if (!freeze) begin
            if_pc_d    = pc_plus4;
            if_inst_d  = skid_q;
            if_valid_d = 1'b1;
            pc_d       = pc_plus4;
            state_d    = StFetch;
          end
        end
        StFlush: begin
          if_inst_d  = INST_NOP;
          if_valid_d = 1'b0;
          state_d    = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  // Request drops combinationally with reset so an abandoned fetch is not re-presented.
  assign imem_req  = rst & (state_q == StFetch);
  assign imem_addr = pc_q;
  assign IF_PC     = if_pc_q;
  assign IF_Inst   = if_inst_q;
  assign IF_valid  = if_valid_q;

`ifdef IF_PERF_CNT_EN
  logic [15:0] redir_q, bubble_q;
  logic        bubble_load;

  assign bubble_load = Br_taken | (state_q == StFlush) |
                       ((state_q == StFetch) & !imem_ack & !freeze);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redir_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (Br_taken && redir_q != 16'hFFFF) redir_q <= redir_q + 16'd1;
      if (bubble_load && bubble_q != 16'hFFFF) bubble_q <= bubble_q + 16'd1;
    end
  end

  assign redir_cnt  = redir_q;
  assign bubble_cnt = bubble_q;
`else
  assign redir_cnt  = 16'h0;
  assign bubble_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the fetch rules.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int MFetch = 0, MHold = 1, MFlush = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze, Br_taken, imem_ack;
  logic [31:0] Br_Addr, imem_rdata;
  logic        imem_req, IF_valid;
  logic [31:0] imem_addr, IF_PC, IF_Inst;
  logic [15:0] redir_cnt, bubble_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          m_mode;
  logic [31:0] m_pc, m_skid, m_ifpc, m_inst;
  logic        m_valid;
  logic [15:0] m_redir, m_bubble;

  if_fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .Br_taken   (Br_taken),
    .Br_Addr    (Br_Addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .IF_PC      (IF_PC),
    .IF_Inst    (IF_Inst),
    .IF_valid   (IF_valid),
    .redir_cnt  (redir_cnt),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got stuck, required finish");
    $fatal(1);
  end

  task automatic model_reset();
    m_mode = MFetch; m_pc = 32'h0; m_skid = 32'h0;
    m_ifpc = 32'h0; m_inst = NOP; m_valid = 1'b0;
    m_redir = 16'h0; m_bubble = 16'h0;
  endtask

  // One clock of the fetch rules: what IF/ID and the PC become after this edge.
  task automatic model_step(input logic frz, input logic br, input logic [31:0] baddr,
                            input logic ack, input logic [31:0] rdata);
    logic bub;
    bub = 1'b0;
    if (br) begin
      m_inst = NOP; m_valid = 1'b0; bub = 1'b1;
      m_mode = (m_mode == MHold) ? MFetch : MFlush;
      m_pc = baddr;
`ifdef IF_PERF_CNT_EN
      if (m_redir != 16'hFFFF) m_redir = m_redir + 16'd1;
`endif
    end else if (m_mode == MFetch) begin
      if (ack && frz) begin
        m_skid = rdata; m_mode = MHold;
      end else if (ack) begin
        m_ifpc = m_pc + 32'd4; m_inst = rdata; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end else if (!frz) begin
        m_inst = NOP; m_valid = 1'b0; bub = 1'b1;
      end
    end else if (m_mode == MHold) begin
      if (!frz) begin
        m_ifpc = m_pc + 32'd4; m_inst = m_skid; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        m_mode = MFetch;
      end
    end else begin
      m_inst = NOP; m_valid = 1'b0; bub = 1'b1; m_mode = MFetch;
    end
`ifdef IF_PERF_CNT_EN
    if (bub && m_bubble != 16'hFFFF) m_bubble = m_bubble + 16'd1;
`endif
  endtask

  // Applies one cycle of stimulus, advances the model, returns 1 time unit after the edge.
  task automatic drive_cycle(input logic frz, input logic br, input logic [31:0] baddr,
                             input logic ack, input logic [31:0] rdata);
    freeze = frz; Br_taken = br; Br_Addr = baddr; imem_ack = ack; imem_rdata = rdata;
    model_step(frz, br, baddr, ack, rdata);
    @(posedge clk);
    #1;
    freeze = 1'b0; Br_taken = 1'b0; imem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #3;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    // Park the DUT mid-request at a non-reset PC, then reset without a clock edge.
    drive_cycle(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    #2;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", imem_req); end
    n_vec++; if (IF_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", IF_valid); end
    n_vec++; if (IF_PC !== 32'h0) begin n_err++; $display("FAIL reset_ifpc got %h want 0", IF_PC); end
    n_vec++; if (IF_Inst !== NOP) begin n_err++; $display("FAIL reset_inst got %h want %h", IF_Inst, NOP); end
    n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", imem_addr); end
    n_vec++;
    if (redir_cnt !== 16'h0 || bubble_cnt !== 16'h0) begin
      n_err++; $display("FAIL reset_cnt got %h/%h want 0/0", redir_cnt, bubble_cnt);
    end
    model_reset();
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL release_req got %b want 1", imem_req); end
  endtask

  task automatic test_zero_latency();
    logic [31:0] d;
    for (int k = 1; k <= 4; k++) begin
      d = $urandom;
      drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, d);
      n_vec++;
      if (IF_PC !== 32'(4 * k) || IF_Inst !== d || IF_valid !== 1'b1) begin
        n_err++;
        $display("FAIL zero_lat[%0d] got pc=%h inst=%h v=%b want pc=%h inst=%h v=1",
                 k, IF_PC, IF_Inst, IF_valid, 32'(4 * k), d);
      end
    end
  endtask

  task automatic test_latency();
    logic [31:0] d;
    drive_cycle(1'b0, 1'b1, 32'h10, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin
      n_err++; $display("FAIL lat_addr got %h req=%b want 00000010 req=1", imem_addr, imem_req);
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++; if (IF_valid !== 1'b0 || IF_Inst !== NOP) begin
      n_err++; $display("FAIL lat_bubble got v=%b inst=%h want v=0 inst=%h", IF_valid, IF_Inst, NOP);
    end
    d = $urandom;
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, d);
    n_vec++; if (IF_PC !== 32'h14 || IF_Inst !== d || IF_valid !== 1'b1) begin
      n_err++; $display("FAIL lat_data got pc=%h inst=%h v=%b want pc=00000014 inst=%h v=1",
                        IF_PC, IF_Inst, IF_valid, d);
    end
  endtask

  task automatic test_freeze();
    logic [31:0] pc0, ifpc0;
    pc0 = imem_addr == m_pc ? m_pc : 32'hx;
    ifpc0 = m_ifpc;
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (IF_PC !== ifpc0 || imem_req !== 1'b0) begin
        n_err++; $display("FAIL freeze_hold[%0d] got pc=%h req=%b want pc=%h req=0",
                          k, IF_PC, imem_req, ifpc0);
      end
      drive_cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
    end
    n_vec++; if (IF_PC !== ifpc0) begin
      n_err++; $display("FAIL freeze_hold3 got pc=%h want %h", IF_PC, ifpc0);
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++; if (IF_Inst !== 32'hDEAD_BEEF || IF_valid !== 1'b1 || IF_PC !== pc0 + 32'd4) begin
      n_err++; $display("FAIL freeze_release got inst=%h v=%b pc=%h want deadbeef v=1 pc=%h",
                        IF_Inst, IF_valid, IF_PC, pc0 + 32'd4);
    end
    n_vec++; if (imem_addr !== pc0 + 32'd4 || imem_req !== 1'b1) begin
      n_err++; $display("FAIL freeze_pc got %h req=%b want %h req=1", imem_addr, imem_req, pc0 + 32'd4);
    end
  endtask

  task automatic test_branch_flush();
    logic [15:0] r0;
    drive_cycle(1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    r0 = redir_cnt;
    drive_cycle(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    n_vec++; if (IF_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_err++; $display("FAIL br_flush got v=%b req=%b want v=0 req=0", IF_valid, imem_req);
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAAD_F00D);
    n_vec++; if (IF_valid !== 1'b0 || IF_Inst !== NOP) begin
      n_err++; $display("FAIL br_late_ack got v=%b inst=%h want v=0 inst=%h", IF_valid, IF_Inst, NOP);
    end
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_err++; $display("FAIL br_target got req=%b addr=%h want req=1 addr=00000100", imem_req, imem_addr);
    end
`ifdef IF_PERF_CNT_EN
    n_vec++; if (redir_cnt !== r0 + 16'd1) begin
      n_err++; $display("FAIL br_redir_cnt got %h want %h", redir_cnt, r0 + 16'd1);
    end
`endif
    n_vec++; if (bubble_cnt !== m_bubble) begin
      n_err++; $display("FAIL br_bubble_cnt got %h want %h", bubble_cnt, m_bubble);
    end
  endtask

  task automatic test_branch_in_hold();
    logic [31:0] d;
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'hBAD0_BAD0);
    drive_cycle(1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    n_vec++; if (IF_valid !== 1'b0 || IF_Inst !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_err++; $display("FAIL hold_br got v=%b inst=%h req=%b addr=%h want v=0 inst=%h req=1 addr=00000200",
                        IF_valid, IF_Inst, imem_req, imem_addr, NOP);
    end
    d = 32'h1111_1111;
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, d);
    n_vec++; if (IF_Inst !== d || IF_PC !== 32'h204) begin
      n_err++; $display("FAIL hold_br_next got inst=%h pc=%h want %h pc=00000204", IF_Inst, IF_PC, d);
    end
  endtask

  task automatic test_wrap();
    drive_cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0001);
    n_vec++; if (IF_PC !== 32'h0 || imem_addr !== 32'h0 || IF_valid !== 1'b1) begin
      n_err++; $display("FAIL wrap got pc=%h addr=%h v=%b want 0/0/1", IF_PC, imem_addr, IF_valid);
    end
  endtask

  task automatic test_random();
    logic frz, br, ack;
    for (int i = 0; i < 400; i++) begin
      frz = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 7) == 0);
      ack = $urandom_range(0, 1) == 1;
      drive_cycle(frz, br, $urandom, ack, $urandom);
      n_vec++; if (IF_PC !== m_ifpc || IF_Inst !== m_inst || IF_valid !== m_valid) begin
        n_err++; $display("FAIL rand_ifid[%0d] got %h/%h/%b want %h/%h/%b",
                          i, IF_PC, IF_Inst, IF_valid, m_ifpc, m_inst, m_valid);
      end
      n_vec++; if (imem_req !== (m_mode == MFetch)) begin
        n_err++; $display("FAIL rand_req[%0d] got %b want %b", i, imem_req, m_mode == MFetch);
      end
      if (m_mode == MFetch) begin
        n_vec++; if (imem_addr !== m_pc) begin
          n_err++; $display("FAIL rand_addr[%0d] got %h want %h", i, imem_addr, m_pc);
        end
      end
      n_vec++; if (redir_cnt !== m_redir || bubble_cnt !== m_bubble) begin
        n_err++; $display("FAIL rand_cnt[%0d] got %h/%h want %h/%h",
                          i, redir_cnt, bubble_cnt, m_redir, m_bubble);
      end
    end
  endtask

  initial begin
    freeze = 1'b0; Br_taken = 1'b0; Br_Addr = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    rst = 1'b0;
    model_reset();
    #12;
    rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_zero_latency();
    test_latency();
    test_freeze();
    do_reset();
    test_branch_flush();
    test_branch_in_hold();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
